// File: rtl/perf_counter_sampler.sv
// Periodically sweeps mhpmcounter3.. over a CSR port and queues {index, value} samples in a FIFO.
// Define PERF_SAMPLER_CLEAR_EN to write each counter back to zero right after it is read.
module perf_counter_sampler #(
    parameter int NumCounters   = 6,
    parameter int FifoDepth     = 8,
    parameter int IntervalWidth = 16,
    parameter int XLEN          = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic [IntervalWidth-1:0] interval_i,
    output logic                     req_o,
    input  logic                     gnt_i,
    output logic [11:0]              addr_o,
    output logic                     we_o,
    output logic [XLEN-1:0]          data_o,
    input  logic [XLEN-1:0]          data_i,
    output logic                     sample_valid_o,
    input  logic                     sample_ready_i,
    output logic [2:0]               sample_idx_o,
    output logic [63:0]              sample_value_o,
    output logic [15:0]              drop_cnt_o,
    output logic                     busy_o
);
    localparam logic [11:0] CSR_MHPM_COUNTER_3  = 12'hB03;
    localparam logic [11:0] CSR_MHPM_COUNTER_3H = 12'hB83;
    localparam int CntW = $clog2(FifoDepth + 1);
    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
`ifdef PERF_SAMPLER_CLEAR_EN
    localparam bit ClearEn = 1'b1;
`else
    localparam bit ClearEn = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, WAIT, RD_LO, RD_HI, CLR, NEXT} state_e;
    typedef struct packed {
        logic [2:0]  idx;
        logic [63:0] value;
    } sample_t;

    state_e                   state_q;
    state_e                   after_read;
    logic [2:0]               k_q;
    logic [IntervalWidth-1:0] ival_q;
    logic [IntervalWidth-1:0] ival_load;
    logic [63:0]              value_q;
    sample_t                  fifo_q [FifoDepth];
    sample_t                  head;
    logic [PtrW-1:0]          wr_ptr_q;
    logic [PtrW-1:0]          rd_ptr_q;
    logic [CntW-1:0]          count_q;
    logic                     push;
    logic                     pop;
    logic                     sweep_ok;

    assign ival_load  = (interval_i == '0) ? IntervalWidth'(1) : interval_i;
    assign after_read = ClearEn ? CLR : NEXT;
    // A sweep only starts when every sample it will produce already has a free slot.
    assign sweep_ok   = int'(count_q) <= FifoDepth - NumCounters;
    assign push       = (state_q == NEXT);
    assign pop        = sample_valid_o && sample_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            k_q        <= '0;
            ival_q     <= '0;
            value_q    <= '0;
            drop_cnt_o <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (enable_i) begin
                    ival_q  <= ival_load;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (!enable_i) begin
                        state_q <= IDLE;
                    end else if (ival_q > IntervalWidth'(1)) begin
                        ival_q <= ival_q - 1'b1;
                    end else if (sweep_ok) begin
                        k_q     <= '0;
                        state_q <= RD_LO;
                    end else begin
                        ival_q <= ival_load;
                        if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 1'b1;
                    end
                end
                RD_LO: if (gnt_i) begin
                    if (XLEN == 64) begin
                        value_q <= 64'(data_i);
                        state_q <= after_read;
                    end else begin
                        value_q[31:0] <= data_i[31:0];
                        state_q       <= RD_HI;
                    end
                end
                RD_HI: if (gnt_i) begin
                    value_q[63:32] <= data_i[31:0];
                    state_q        <= after_read;
                end
                CLR: if (gnt_i) state_q <= NEXT;
                NEXT: begin
                    if (k_q != 3'(NumCounters - 1)) begin
                        k_q     <= k_q + 1'b1;
                        state_q <= RD_LO;
                    end else if (enable_i) begin
                        ival_q  <= ival_load;
                        state_q <= WAIT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_o  = state_q inside {RD_LO, RD_HI, CLR};
    assign busy_o = !(state_q inside {IDLE, WAIT});
    assign we_o   = ClearEn && (state_q == CLR);
    assign data_o = '0;

    always_comb begin
        // NOTE: default assignment first so every path drives addr_o and no latch is inferred.
        addr_o = '0;
        case (state_q)
            RD_LO, CLR: addr_o = CSR_MHPM_COUNTER_3 + 12'(k_q);
            RD_HI:      addr_o = CSR_MHPM_COUNTER_3H + 12'(k_q);
            default:    addr_o = '0;
        endcase
    end

    // NOTE: sample storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push) fifo_q[wr_ptr_q] <= '{idx: k_q, value: value_q};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(FifoDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(FifoDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    assign head           = fifo_q[rd_ptr_q];
    assign sample_valid_o = (count_q != '0);
    assign sample_idx_o   = head.idx;
    assign sample_value_o = head.value;

endmodule

// File: tb/tb_perf_counter_sampler.sv
// Directed/randomized bench for perf_counter_sampler: a 64-bit and a 32-bit instance against
// CSR counter models and a scoreboard of expected sweeps snapshotted from the model counters.
module tb_perf_counter_sampler;
    localparam int N = 6;
`ifdef PERF_SAMPLER_CLEAR_EN
    localparam int ClrEn = 1;
`else
    localparam int ClrEn = 0;
`endif
    localparam logic [11:0] Base  = 12'hB03;
    localparam logic [11:0] BaseH = 12'hB83;

    typedef struct {
        int          idx;
        logic [63:0] val;
    } sample_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        en, req, gnt, we, valid, ready, busy;
    logic [15:0] ival, drop;
    logic [11:0] addr;
    logic [63:0] wdata, rdata, value;
    logic [2:0]  idx;

    logic        en_b, req_b, gnt_b, we_b, valid_b, ready_b, busy_b;
    logic [15:0] drop_b;
    logic [11:0] addr_b;
    logic [31:0] wdata_b, rdata_b;
    logic [63:0] value_b;
    logic [2:0]  idx_b;

    perf_counter_sampler #(.NumCounters(N), .FifoDepth(8), .IntervalWidth(16), .XLEN(64)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .interval_i(ival),
        .req_o(req), .gnt_i(gnt), .addr_o(addr), .we_o(we), .data_o(wdata), .data_i(rdata),
        .sample_valid_o(valid), .sample_ready_i(ready), .sample_idx_o(idx), .sample_value_o(value),
        .drop_cnt_o(drop), .busy_o(busy)
    );

    perf_counter_sampler #(.NumCounters(N), .FifoDepth(8), .IntervalWidth(16), .XLEN(32)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en_b), .interval_i(ival),
        .req_o(req_b), .gnt_i(gnt_b), .addr_o(addr_b), .we_o(we_b), .data_o(wdata_b), .data_i(rdata_b),
        .sample_valid_o(valid_b), .sample_ready_i(ready_b), .sample_idx_o(idx_b), .sample_value_o(value_b),
        .drop_cnt_o(drop_b), .busy_o(busy_b)
    );

    // Counter files seen through the CSR port.
    logic [63:0] ctr   [N];
    logic [63:0] ctr_b [N];

    always_comb begin
        rdata = '0;
        for (int i = 0; i < N; i++) if (addr == Base + 12'(i)) rdata = ctr[i];
    end

    always_comb begin
        rdata_b = '0;
        for (int i = 0; i < N; i++) begin
            if (addr_b == Base + 12'(i))  rdata_b = ctr_b[i][31:0];
            if (addr_b == BaseH + 12'(i)) rdata_b = ctr_b[i][63:32];
        end
    end

    int checks = 0;
    int errors = 0;

    sample_t     exp_q[$];
    sample_t     exp_qb[$];
    logic [11:0] addr_log_b[$];
    bit          prev_busy, prev_busy_b, stall, toggle_gnt, rand_ready;
    logic [11:0] held_addr, last_rd;
    logic [63:0] first_val_b;
    int busy_run, last_run, busy_run_b, last_run_b;
    int pops, pops_b, writes, writes_b, req_cycles;
    int clr_idx = -1;
    int clr_idx_b = -1;

    task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs at a falling edge with this cycle's inputs final: judges what the next rising edge does.
    task automatic monitor();
        sample_t e;
        if (!rst_n) begin
            exp_q.delete();
            prev_busy = 1'b0;
            stall     = 1'b0;
            return;
        end
        if (busy && !prev_busy) begin
            for (int i = 0; i < N; i++) exp_q.push_back('{idx: i, val: ctr[i]});
            busy_run = 0;
        end
        if (busy) busy_run++;
        else if (prev_busy) last_run = busy_run;
        prev_busy = busy;
        if (stall) check(64'(addr), 64'(held_addr), "addr_hold_on_stall");
        stall     = req && !gnt;
        held_addr = addr;
        if (req) req_cycles++;
        if (req && gnt) begin
            if (!we) begin
                last_rd = addr;
            end else begin
                writes++;
                check(64'(addr), 64'(last_rd), "clear_addr");
                check(wdata, 64'd0, "clear_data");
                clr_idx = int'(addr - Base);
            end
        end
        if (valid && ready) begin
            if (exp_q.size() == 0) begin
                check(64'(valid), 64'd0, "unexpected_sample");
            end else begin
                e = exp_q.pop_front();
                check(64'(idx), 64'(e.idx), "sample_idx");
                check(value, e.val, "sample_value");
                pops++;
            end
        end
    endtask

    task automatic monitor_b();
        sample_t e;
        if (!rst_n) begin
            exp_qb.delete();
            prev_busy_b = 1'b0;
            return;
        end
        if (busy_b && !prev_busy_b) begin
            for (int i = 0; i < N; i++) exp_qb.push_back('{idx: i, val: ctr_b[i]});
            busy_run_b = 0;
        end
        if (busy_b) busy_run_b++;
        else if (prev_busy_b) last_run_b = busy_run_b;
        prev_busy_b = busy_b;
        if (req_b && gnt_b) begin
            addr_log_b.push_back(addr_b);
            if (we_b) begin
                writes_b++;
                check(64'(wdata_b), 64'd0, "b_clear_data");
                clr_idx_b = int'(addr_b - Base);
            end
        end
        if (valid_b && ready_b) begin
            if (exp_qb.size() == 0) begin
                check(64'(valid_b), 64'd0, "b_unexpected_sample");
            end else begin
                e = exp_qb.pop_front();
                if (pops_b == 0) first_val_b = value_b;
                check(64'(idx_b), 64'(e.idx), "b_sample_idx");
                check(value_b, e.val, "b_sample_value");
                pops_b++;
            end
        end
    endtask

    task automatic step();
        monitor();
        monitor_b();
        @(negedge clk);
        if (clr_idx >= 0 && clr_idx < N) ctr[clr_idx] = '0;
        if (clr_idx_b >= 0 && clr_idx_b < N) ctr_b[clr_idx_b] = '0;
        clr_idx   = -1;
        clr_idx_b = -1;
        if (toggle_gnt) gnt = busy ? ~gnt : 1'b1;
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_busy(input logic level, input int budget, input string tag);
        int n = 0;
        while (busy !== level && n < budget) begin
            step();
            n++;
        end
        check(64'(busy), 64'(level), tag);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        rand_ready = 1'b0;
        ready = 1'b1;
        while ((valid || exp_q.size() != 0) && n < 100) begin
            step();
            n++;
        end
        check(64'(exp_q.size()), 64'd0, {tag, "_drained"});
        check(64'(valid), 64'd0, {tag, "_fifo_empty"});
    endtask

    // One sweep with enable dropped as soon as it starts, so exactly one sweep runs before IDLE.
    task automatic run_sweep(input bit timed, input string tag);
        int n;
        int w0 = writes;
        int p0 = pops;
        en = 1'b1;
        wait_busy(1'b1, 200, {tag, "_start"});
        en = 1'b0;
        n = 1;
        while (!valid && n < 100) begin
            step();
            n++;
        end
        if (timed) check(64'(n), 64'(ClrEn + 3), {tag, "_first_valid"});
        wait_busy(1'b0, 200, {tag, "_end"});
        step();
        if (timed) check(64'(last_run), 64'(N * (ClrEn + 2)), {tag, "_latency"});
        drain(tag);
        check(64'(pops - p0), 64'(N), {tag, "_pops"});
        check(64'(writes - w0), 64'(N * ClrEn), {tag, "_clears"});
    endtask

    initial begin
        int n, p0, rc0;
        rst_n = 1'b0; en = 1'b0; en_b = 1'b0; ival = 16'd10;
        gnt = 1'b1; gnt_b = 1'b1; ready = 1'b1; ready_b = 1'b1;
        toggle_gnt = 1'b0; rand_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            ctr[i]   = 64'h11 * 64'(i + 1);
            ctr_b[i] = {$urandom, $urandom};
        end
        ctr_b[0] = 64'h0000_0001_FFFF_FFFF;
        repeat (2) step();
        rst_n = 1'b1;
        check(64'(req), 64'd0, "rst_req");
        check(64'(addr), 64'd0, "rst_addr");
        check(64'(we), 64'd0, "rst_we");
        check(wdata, 64'd0, "rst_data");
        check(64'(valid), 64'd0, "rst_valid");
        check(64'(busy), 64'd0, "rst_busy");
        check(64'(drop), 64'd0, "rst_drop");
        check(64'(req_b), 64'd0, "rst_b_req");
        check(64'(drop_b), 64'd0, "rst_b_drop");

        // Known counter values 0x11..0x66, interval 10, grant always high.
        run_sweep(1'b1, "basic");

        // 32-bit port: low half then high half per counter.
        en_b = 1'b1;
        n = 0;
        while (!busy_b && n < 200) begin step(); n++; end
        check(64'(busy_b), 64'd1, "b_start");
        en_b = 1'b0;
        n = 0;
        while ((busy_b || valid_b) && n < 200) begin step(); n++; end
        step();
        check(64'(addr_log_b[0]), 64'hB03, "b_addr_lo");
        check(64'(addr_log_b[1]), 64'hB83, "b_addr_hi");
        check(first_val_b, 64'h0000_0001_FFFF_FFFF, "b_first_value");
        check(64'(last_run_b), 64'(N * (ClrEn + 3)), "b_latency");
        check(64'(pops_b), 64'(N), "b_pops");
        check(64'(writes_b), 64'(N * ClrEn), "b_clears");

        // Same counter values with the grant stalling every other cycle and a random consumer.
        for (int i = 0; i < N; i++) ctr[i] = 64'h11 * 64'(i + 1);
        toggle_gnt = 1'b1;
        rand_ready = 1'b1;
        run_sweep(1'b0, "gnt_toggle");
        toggle_gnt = 1'b0;
        gnt = 1'b1;

        // No reload: in clear mode the previous sweep zeroed every counter.
        run_sweep(1'b1, "reread");

        // Random counter values and intervals, including interval 0 (treated as 1).
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < N; i++) ctr[i] = {$urandom, $urandom};
            ival = (t == 0) ? 16'd0 : 16'($urandom_range(1, 20));
            run_sweep(1'b1, "random");
        end

        // Stalled consumer: one sweep fits, the next one is dropped.
        for (int i = 0; i < N; i++) ctr[i] = {$urandom, $urandom};
        ival = 16'd10;
        ready = 1'b0;
        p0 = pops;
        en = 1'b1;
        n = 0;
        while (drop == 16'd0 && n < 300) begin step(); n++; end
        en = 1'b0;
        repeat (5) step();
        check(64'(drop), 64'd1, "drop_cnt");
        check(64'(valid), 64'd1, "drop_fifo_held");
        check(64'(busy), 64'd0, "drop_idle");
        drain("drop");
        check(64'(pops - p0), 64'(N), "drop_pops");

        // Enable falls at k=2: the sweep still finishes all counters.
        for (int i = 0; i < N; i++) ctr[i] = {$urandom, $urandom};
        p0 = pops;
        en = 1'b1;
        wait_busy(1'b1, 200, "late_off_start");
        n = 0;
        while (!(req && addr == Base + 12'd2) && n < 50) begin step(); n++; end
        check(64'(addr), 64'(Base + 12'd2), "late_off_k2");
        en = 1'b0;
        wait_busy(1'b0, 200, "late_off_end");
        step();
        drain("late_off");
        check(64'(pops - p0), 64'(N), "late_off_pops");
        repeat (15) step();
        check(64'(busy), 64'd0, "late_off_idle");

        // Reset in the middle of the next sweep abandons it.
        en = 1'b1;
        wait_busy(1'b1, 200, "mid_rst_start");
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        en = 1'b0;
        rc0 = req_cycles;
        check(64'(req), 64'd0, "mid_rst_req");
        check(64'(addr), 64'd0, "mid_rst_addr");
        check(64'(valid), 64'd0, "mid_rst_valid");
        check(64'(busy), 64'd0, "mid_rst_busy");
        check(64'(drop), 64'd0, "mid_rst_drop");
        repeat (15) step();
        check(64'(req_cycles - rc0), 64'd0, "mid_rst_no_access");
        check(64'(valid), 64'd0, "mid_rst_no_push");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
